alsu_sched: RTL and testbench
=============================

# alsu_sched

Two-requester command scheduler for the 3-bit ALSU. It arbitrates command streams from two requesters, issues at most one command per cycle into the ALSU's packed input bundle, and tags each issued command. It returns each ALSU result to its requester after a fixed latency. Optional burst locking keeps shift/rotate chains from one requester on consecutive ALSU cycles.

## Interface
- ALSU_LAT, 2: ALSU cycles from input-bundle capture edge to result-register update edge, plus one (input reg + output reg).
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- req_valid  input  2  per-requester command valid
- req_ready  output  2  per-requester accept; may depend combinationally on req_valid
- req_lock  input  2  hold grant for the next command (see Configuration)
- req_cmd0, req_cmd1  input  16  command: [2:0] A, [5:3] B, [8:6] opcode, [9] cin, [10] serial_in, [11] direction, [12] red_op_A, [13] red_op_B, [14] bypass_A, [15] bypass_B
- alsu_cmd  output  16  registered bundle to the ALSU inputs, same field layout
- alsu_out  input  6  ALSU result
- rsp_valid  output  1  result pulse, one cycle, no backpressure
- rsp_id  output  1  requester that owns the result
- rsp_data  output  6  captured alsu_out
- rsp_invalid  output  1  command was an invalid ALSU combination; data forced 0

## Operation
- Accept: the transfer on requester i happens when req_valid[i] & req_ready[i] at a clk edge. At most one req_ready bit is high per cycle.
- Round-robin arbitration:
  - Both valid: grant the requester not granted last.
  - One valid: grant it.
  - Last-grant pointer updates only on an accept. Reset value makes requester 0 win first.
- Issue: on accept, alsu_cmd <= req_cmd of the granted requester. With no accept, alsu_cmd <= IDLE_CMD (16'h0000: AND of zeros), which drives the ALSU result to 0 two edges later.
- Tag pipeline: ALSU_LAT+1 stages of {valid, id, invalid}. It is loaded on every cycle; idle cycles load valid=0.
- Response: when the stage-end entry is valid, register rsp_valid=1, rsp_id, rsp_invalid, and rsp_data=alsu_out.
- Invalid flag: ((red_op_A|red_op_B)&(opcode[1]|opcode[2]) | opcode[1]&opcode[2]) & ~bypass_A & ~bypass_B.
- Shift/rotate (opcodes 4/5) act on the previous ALSU result. That result belongs to the previous command only if both commands were accepted on consecutive cycles. After any idle cycle, the previous result is 0.
- Reset mid-operation clears all in-flight tags; no response is produced for commands accepted before reset.

## Timing
- Cycle t: accept.
- t+1: alsu_cmd presented.
- End of t+1: ALSU input regs capture.
- End of t+2: alsu_out updates.
- End of t+3: rsp registered.
- rsp_valid is high in cycle t+4 (latency ALSU_LAT+2 = 4).
- Throughput: one command per cycle sustained; responses return in accept order.
- Reset values: req_ready=0 while rst is high; alsu_cmd=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_invalid=0; last-grant pointer=1; lock state cleared.

## Configuration
- ALSU_SCHED_LOCK_EN defined:
  - An accept with req_lock[i]=1 sets lock owner i.
  - While locked, only requester i can be granted. Idle cycles are allowed and do not release the lock.
  - The lock releases after accepting a command from i with req_lock[i]=0.
- Not defined: req_lock is ignored and arbitration is pure round-robin.

## Structure
- Package alsu_pkg:
  - CMD_W=16
  - field bit offsets
  - opcode constants OP_AND, OP_XOR, OP_ADD, OP_MUL, OP_SHIFT, OP_ROT
  - IDLE_CMD
  - the invalid-flag function
- Sub-module alsu_rr_arb: 2-way round-robin grant with optional lock. Inputs: valid, lock, accept. Output: one-hot grant.
- The top level holds the alsu_cmd register, tag pipeline and response register.

## Test plan
- Req0 only, A=3 B=5 opcode=3 -> rsp_valid 4 cycles after accept, rsp_id=0, rsp_data=15, rsp_invalid=0.
- Both valid continuously, A=1 B=2 opcode=2 cin=1 -> accepts alternate 0,1,0,1 starting with 0; every rsp_data=4; rsp_id alternates; one rsp per cycle.
- ALSU_SCHED_LOCK_EN, req1 also valid throughout. Req0 sends three commands back-to-back:
  - bypass_A A=5 lock=1
  - opcode=4 direction=1 serial_in=1 lock=1
  - the same shift with lock=0
  - Required: req1 is not granted until after the third accept; req0 responses are 5, 11, 23.
- opcode=6 -> rsp_data=0, rsp_invalid=1. opcode=2 red_op_A=1 -> rsp_invalid=1. opcode=6 bypass_B=1 B=7 -> rsp_data=7, rsp_invalid=0.
- Accept a command, then assert rst for one cycle at t+2 -> no rsp_valid ever; all outputs 0 during reset; after release, req0 wins the first contention.
- Idle cycle, then opcode=4 direction=0 serial_in=1 -> rsp_data=32.

Source files
------------

// File: rtl/alsu_pkg.sv
// Shared ALSU scheduler definitions: command field layout, opcodes, idle command, invalid check.
package alsu_pkg;
  localparam int CMD_W     = 16;
  localparam int ALSU_LAT  = 2;
  localparam int TAG_DEPTH = ALSU_LAT + 1;

  localparam int A_LSB      = 0;
  localparam int B_LSB      = 3;
  localparam int OP_LSB     = 6;
  localparam int CIN_BIT    = 9;
  localparam int SERIAL_BIT = 10;
  localparam int DIR_BIT    = 11;
  localparam int RED_A_BIT  = 12;
  localparam int RED_B_BIT  = 13;
  localparam int BYP_A_BIT  = 14;
  localparam int BYP_B_BIT  = 15;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_XOR   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_ROT   = 3'd5;

  // AND of zeros: keeps the ALSU result at 0 on cycles with nothing to issue.
  localparam logic [CMD_W-1:0] IDLE_CMD = '0;

  typedef struct packed {
    logic valid;
    logic id;
    logic invalid;
  } tag_t;

  function automatic logic cmd_invalid(input logic [CMD_W-1:0] cmd);
    logic [2:0] op;
    op = cmd[OP_LSB +: 3];
    return (((cmd[RED_A_BIT] | cmd[RED_B_BIT]) & (op[1] | op[2])) | (op[1] & op[2]))
           & ~cmd[BYP_A_BIT] & ~cmd[BYP_B_BIT];
  endfunction
endpackage

// File: rtl/alsu_rr_arb.sv
// Two-way round-robin arbiter; with ALSU_SCHED_LOCK_EN a requester can hold the grant
// across commands until it accepts one with its lock bit low.
module alsu_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic [1:0] lock,
  input  logic       accept,
  output logic [1:0] grant
);
  logic last_reg;
  logic winner;

`ifdef ALSU_SCHED_LOCK_EN
  logic locked_reg;
  logic owner_reg;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  always_comb begin
    winner = (valid == 2'b11) ? ~last_reg : valid[1];
`ifdef ALSU_SCHED_LOCK_EN
    if (locked_reg) winner = owner_reg;
`endif
    grant = 2'b00;
    grant[winner] = valid[winner];
  end

  // Pointer starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_reg <= 1'b1;
`ifdef ALSU_SCHED_LOCK_EN
      locked_reg <= 1'b0;
      owner_reg  <= 1'b0;
`endif
    end else if (accept) begin
      last_reg <= winner;
`ifdef ALSU_SCHED_LOCK_EN
      locked_reg <= lock[winner];
      owner_reg  <= winner;
`endif
    end
  end
endmodule

// File: rtl/alsu_sched.sv
// Two-requester ALSU command scheduler: issues one command per cycle and returns tagged
// results ALSU_LAT+2 cycles after accept. Burst locking enabled by ALSU_SCHED_LOCK_EN.
module alsu_sched
  import alsu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_lock,
  input  logic [CMD_W-1:0] req_cmd0,
  input  logic [CMD_W-1:0] req_cmd1,
  output logic [CMD_W-1:0] alsu_cmd,
  input  logic [5:0]       alsu_out,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [5:0]       rsp_data,
  output logic             rsp_invalid
);
  logic [1:0]       grant;
  logic             accept;
  logic             accept_id;
  logic [CMD_W-1:0] sel_cmd;
  tag_t             tag_in;
  tag_t             tag_end;
  tag_t             tag_reg [TAG_DEPTH];

  alsu_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .lock   (req_lock),
    .accept (accept),
    .grant  (grant)
  );

  assign req_ready = rst ? 2'b00 : grant;
  assign accept    = |(req_valid & req_ready);
  assign accept_id = grant[1];
  assign sel_cmd   = accept_id ? req_cmd1 : req_cmd0;

  always_comb begin
    tag_in         = '0;
    tag_in.valid   = accept;
    tag_in.id      = accept_id;
    tag_in.invalid = accept & cmd_invalid(sel_cmd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alsu_cmd <= IDLE_CMD;
    end else begin
      alsu_cmd <= accept ? sel_cmd : IDLE_CMD;
    end
  end

  // Tags travel alongside the command through the ALSU's input and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAG_DEPTH; i++) tag_reg[i] <= '0;
    end else begin
      tag_reg[0] <= tag_in;
      for (int i = 1; i < TAG_DEPTH; i++) tag_reg[i] <= tag_reg[i-1];
    end
  end

  assign tag_end = tag_reg[TAG_DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
      rsp_invalid <= 1'b0;
    end else begin
      rsp_valid <= tag_end.valid;
      if (tag_end.valid) begin
        rsp_id      <= tag_end.id;
        rsp_invalid <= tag_end.invalid;
        rsp_data    <= tag_end.invalid ? 6'd0 : alsu_out;
      end
    end
  end
endmodule

// File: tb/tb_alsu_sched.sv
// Bench for alsu_sched: emulates the ALSU, checks directed vectors, corner sequences and a
// randomized run against a transaction-level model. Lock checks apply under ALSU_SCHED_LOCK_EN.
module tb_alsu_sched;
  import alsu_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_lock;
  logic [CMD_W-1:0] req_cmd0;
  logic [CMD_W-1:0] req_cmd1;
  logic [CMD_W-1:0] alsu_cmd;
  logic [5:0]       alsu_out;
  logic             rsp_valid;
  logic             rsp_id;
  logic [5:0]       rsp_data;
  logic             rsp_invalid;

  int n_cmp = 0;
  int n_bad = 0;

  alsu_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1), .alsu_cmd(alsu_cmd), .alsu_out(alsu_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_invalid(rsp_invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [15:0] mk(input int a, input int b, input int op, input int cin = 0,
                                     input int si = 0, input int dir = 0, input int ra = 0,
                                     input int rb = 0, input int ba = 0, input int bb = 0);
    logic [15:0] c;
    c = '0;
    c[2:0] = a[2:0];   c[5:3] = b[2:0];   c[8:6] = op[2:0];
    c[9] = cin[0];     c[10] = si[0];     c[11] = dir[0];
    c[12] = ra[0];     c[13] = rb[0];     c[14] = ba[0];     c[15] = bb[0];
    return c;
  endfunction

  // 3-bit ALSU behaviour: bypass A has priority, reduction of A has priority over B.
  function automatic logic [5:0] alsu_f(input logic [15:0] c, input logic [5:0] prev);
    logic [2:0] a, b;
    int op;
    logic bad;
    a = c[2:0]; b = c[5:3]; op = int'(c[8:6]);
    bad = ((op >= 6) || ((c[12] || c[13]) && op >= 2)) && !c[14] && !c[15];
    if (bad) return 6'd0;
    if (c[14]) return {3'b000, a};
    if (c[15]) return {3'b000, b};
    case (op)
      0: return c[12] ? {5'b0, &a} : c[13] ? {5'b0, &b} : {3'b000, a & b};
      1: return c[12] ? {5'b0, ^a} : c[13] ? {5'b0, ^b} : {3'b000, a ^ b};
      2: return 6'(int'(a) + int'(b) + int'(c[9]));
      3: return 6'(int'(a) * int'(b));
      4: return c[11] ? {prev[4:0], c[10]} : {c[10], prev[5:1]};
      5: return c[11] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic alsu_bad(input logic [15:0] c);
    int op;
    op = int'(c[8:6]);
    return ((op >= 6) || ((c[12] || c[13]) && op >= 2)) && !c[14] && !c[15];
  endfunction

  // ALSU stand-in: input register then result register.
  logic [15:0] alsu_in_q;
  logic [5:0]  alsu_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alsu_in_q <= '0;
      alsu_q    <= '0;
    end else begin
      alsu_in_q <= alsu_cmd;
      alsu_q    <= alsu_f(alsu_in_q, alsu_q);
    end
  end
  assign alsu_out = alsu_q;

  // Transaction model: accepts become expected responses due four cycles later.
  typedef struct {
    int         due;
    logic       id;
    logic [5:0] data;
    logic       inv;
  } exp_t;
  exp_t sb[$];
  int   cyc = 0;
  logic m_last = 1'b1, m_locked = 1'b0, m_owner = 1'b0, m_prev_acc = 1'b0;
  logic [5:0] m_prev = '0;

  initial begin : monitor
    logic exp_v, win, id;
    logic [1:0] m_ready;
    logic [15:0] c;
    logic [5:0] res;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        sb.delete();
        m_last = 1'b1; m_locked = 1'b0; m_owner = 1'b0; m_prev_acc = 1'b0; m_prev = '0;
      end
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      check("mon_rsp_valid", 16'(rsp_valid), 16'(exp_v));
      if (exp_v) begin
        if (rsp_valid) begin
          check("mon_rsp_id", 16'(rsp_id), 16'(sb[0].id));
          check("mon_rsp_data", 16'(rsp_data), 16'(sb[0].data));
          check("mon_rsp_invalid", 16'(rsp_invalid), 16'(sb[0].inv));
        end
        void'(sb.pop_front());
      end
      if (rst) begin
        check("mon_ready_in_rst", 16'(req_ready), 16'(0));
        m_prev_acc = 1'b0;
      end else begin
        if (req_valid == 2'b11) win = ~m_last;
        else win = req_valid[1];
`ifdef ALSU_SCHED_LOCK_EN
        if (m_locked) win = m_owner;
`endif
        m_ready = 2'b00;
        if (req_valid[win]) m_ready[win] = 1'b1;
        check("mon_req_ready", 16'(req_ready), 16'(m_ready));
        if (m_ready != 2'b00) begin
          id  = m_ready[1];
          c   = id ? req_cmd1 : req_cmd0;
          res = alsu_f(c, m_prev_acc ? m_prev : 6'd0);
          sb.push_back('{due: cyc + 4, id: id, data: alsu_bad(c) ? 6'd0 : res, inv: alsu_bad(c)});
          m_prev = res;
          m_last = id;
`ifdef ALSU_SCHED_LOCK_EN
          m_locked = req_lock[id];
          m_owner  = id;
`endif
          m_prev_acc = 1'b1;
        end else begin
          m_prev_acc = 1'b0;
        end
      end
      cyc++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  typedef struct packed {
    logic [15:0] cmd;
    logic [5:0]  data;
    logic        inv;
  } vec_t;
  localparam int NV = 13;
  vec_t tbl [NV];
  logic [15:0] chain_cmd [3];
  logic        chain_lk  [3];
  logic [5:0]  chain_exp [3];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b00; req_lock = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_cmd();
    logic [15:0] c;
    c = 16'($urandom);
    if ($urandom_range(0, 3) != 0) c[15:12] = 4'b0000;
    return c;
  endfunction

  initial begin
    logic got;
    int n;
    tbl[0]  = '{cmd: mk(3, 5, int'(OP_MUL)), data: 6'd15, inv: 1'b0};
    tbl[1]  = '{cmd: mk(3, 5, 6), data: 6'd0, inv: 1'b1};
    tbl[2]  = '{cmd: mk(3, 5, int'(OP_ADD), 0, 0, 0, 1), data: 6'd0, inv: 1'b1};
    tbl[3]  = '{cmd: mk(2, 7, 6, 0, 0, 0, 0, 0, 0, 1), data: 6'd7, inv: 1'b0};
    tbl[4]  = '{cmd: mk(6, 3, int'(OP_XOR)), data: 6'd5, inv: 1'b0};
    tbl[5]  = '{cmd: mk(7, 5, int'(OP_AND)), data: 6'd5, inv: 1'b0};
    tbl[6]  = '{cmd: mk(7, 0, int'(OP_AND), 0, 0, 0, 1), data: 6'd1, inv: 1'b0};
    tbl[7]  = '{cmd: mk(0, 7, int'(OP_XOR), 0, 0, 0, 0, 1), data: 6'd1, inv: 1'b0};
    tbl[8]  = '{cmd: mk(7, 7, int'(OP_ADD), 1), data: 6'd15, inv: 1'b0};
    tbl[9]  = '{cmd: mk(0, 0, int'(OP_SHIFT), 0, 1, 0), data: 6'd32, inv: 1'b0};
    tbl[10] = '{cmd: mk(4, 2, 7, 0, 0, 0, 0, 0, 1, 1), data: 6'd4, inv: 1'b0};
    tbl[11] = '{cmd: mk(7, 7, int'(OP_MUL)), data: 6'd49, inv: 1'b0};
    tbl[12] = '{cmd: mk(1, 1, int'(OP_ROT), 0, 0, 0, 0, 1), data: 6'd0, inv: 1'b1};
    chain_cmd[0] = mk(5, 0, 0, 0, 0, 0, 0, 0, 1); chain_lk[0] = 1'b1; chain_exp[0] = 6'd5;
    chain_cmd[1] = mk(0, 0, int'(OP_SHIFT), 0, 1, 1); chain_lk[1] = 1'b1; chain_exp[1] = 6'd11;
    chain_cmd[2] = mk(0, 0, int'(OP_SHIFT), 0, 1, 1); chain_lk[2] = 1'b0; chain_exp[2] = 6'd23;

    rst = 1'b1; req_valid = 2'b00; req_lock = 2'b00; req_cmd0 = '0; req_cmd1 = '0;
    repeat (2) @(negedge clk);
    req_valid = 2'b11; req_cmd0 = mk(3, 5, 3);
    #1;
    check("rst_req_ready", 16'(req_ready), 16'(0));
    check("rst_alsu_cmd", alsu_cmd, 16'(0));
    check("rst_rsp_valid", 16'(rsp_valid), 16'(0));
    check("rst_rsp_id", 16'(rsp_id), 16'(0));
    check("rst_rsp_data", 16'(rsp_data), 16'(0));
    check("rst_rsp_invalid", 16'(rsp_invalid), 16'(0));
    @(negedge clk);
    req_valid = 2'b00; rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed vectors from requester 0, each preceded by idle cycles.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      req_cmd0 = tbl[i].cmd; req_valid = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      got = 1'b0; n = 1;
      while (!got && n <= 8) begin
        if (rsp_valid) got = 1'b1;
        else begin
          @(negedge clk); #1; n++;
        end
      end
      check($sformatf("vec%0d_seen", i), 16'(got), 16'(1));
      if (got) begin
        check($sformatf("vec%0d_latency", i), 16'(n), 16'(4));
        check($sformatf("vec%0d_id", i), 16'(rsp_id), 16'(0));
        check($sformatf("vec%0d_data", i), 16'(rsp_data), 16'(tbl[i].data));
        check($sformatf("vec%0d_invalid", i), 16'(rsp_invalid), 16'(tbl[i].inv));
      end
      repeat (2) @(negedge clk);
    end

    // Continuous contention: grants alternate from 0, one response per cycle.
    do_reset();
    req_cmd0 = mk(1, 2, int'(OP_ADD), 1); req_cmd1 = mk(1, 2, int'(OP_ADD), 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_valid = (i < 8) ? 2'b11 : 2'b00;
      #1;
      if (i < 8) check($sformatf("rr_ready%0d", i), 16'(req_ready), 16'((i % 2 == 0) ? 1 : 2));
      if (i >= 4) begin
        check($sformatf("rr_rsp_valid%0d", i), 16'(rsp_valid), 16'(1));
        check($sformatf("rr_rsp_id%0d", i), 16'(rsp_id), 16'((i - 4) % 2));
        check($sformatf("rr_rsp_data%0d", i), 16'(rsp_data), 16'(4));
      end
    end

    // Back-to-back chain from requester 0; with locking requester 1 competes throughout.
    do_reset();
    req_cmd1 = mk(0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 3) begin
        req_cmd0 = chain_cmd[i];
        req_lock = {1'b0, chain_lk[i]};
`ifdef ALSU_SCHED_LOCK_EN
        req_valid = 2'b11;
`else
        req_valid = 2'b01;
`endif
      end else if (i == 3) begin
        req_lock = 2'b00;
`ifdef ALSU_SCHED_LOCK_EN
        req_valid = 2'b11;
`else
        req_valid = 2'b00;
`endif
      end else begin
        req_valid = 2'b00;
      end
      #1;
      if (i < 3) check($sformatf("chain_ready%0d", i), 16'(req_ready), 16'(1));
`ifdef ALSU_SCHED_LOCK_EN
      if (i == 3) check("lock_release_ready", 16'(req_ready), 16'(2));
`endif
      if (i >= 4) begin
        check($sformatf("chain_rsp_valid%0d", i - 4), 16'(rsp_valid), 16'(1));
        check($sformatf("chain_rsp_id%0d", i - 4), 16'(rsp_id), 16'(0));
        check($sformatf("chain_rsp_data%0d", i - 4), 16'(rsp_data), 16'(chain_exp[i - 4]));
      end
    end
    repeat (4) @(negedge clk);

    // Reset two cycles after an accept drops the in-flight response.
    @(negedge clk);
    req_cmd0 = mk(3, 5, int'(OP_MUL)); req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b11;
    #1;
    check("midrst_req_ready", 16'(req_ready), 16'(0));
    check("midrst_alsu_cmd", alsu_cmd, 16'(0));
    check("midrst_rsp_valid", 16'(rsp_valid), 16'(0));
    check("midrst_rsp_data", 16'(rsp_data), 16'(0));
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("midrst_no_rsp%0d", i), 16'(rsp_valid), 16'(0));
    end
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    check("midrst_first_grant", 16'(req_ready), 16'(1));
    @(negedge clk);
    req_valid = 2'b00;

    // Randomized traffic, including one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst = (i == 200);
      req_valid = 2'($urandom_range(0, 3));
      req_lock  = 2'($urandom_range(0, 3));
      req_cmd0  = rand_cmd();
      req_cmd1  = rand_cmd();
    end
    @(negedge clk);
    req_valid = 2'b00; req_lock = 2'b00;
    repeat (10) @(negedge clk);
    #2;
    check("drain_outstanding", 16'(sb.size()), 16'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
